// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// broadcast of one held result per cycle onto a registered CDB.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [1:0]              cdb_src
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  hv;
  logic [N_REQ-1:0]  grant;
  logic [TAG_W-1:0]  ht [N_REQ];
  logic [DATA_W-1:0] hd [N_REQ];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  rr_next;
  logic              any_held;

  // Winner is the first held slot scanning upward from rr_ptr; req_valid is
  // deliberately not involved so a fresh request never steals the bus.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    win      = '0;
    any_held = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_held && hv[idx]) begin
        any_held = 1'b1;
        win      = PTR_W'(idx);
      end
    end
    if (any_held) grant[win] = 1'b1;
    rr_next = (int'(win) == N_REQ - 1) ? '0 : win + PTR_W'(1);
  end

  // The granted slot drains this edge, so it may refill in the same cycle.
  assign req_ready = {N_REQ{~flush}} & (~hv | grant);

  always_ff @(posedge clk1) begin
    if (rst) begin
      hv        <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      hv        <= '0;
      cdb_valid <= 1'b0;
    end else begin
      if (any_held) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= ht[win];
        cdb_data  <= hd[win];
        cdb_src   <= 2'(win);
        rr_ptr    <= rr_next;
      end else begin
        cdb_valid <= 1'b0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hv[i] <= 1'b1;
          ht[i] <= req_tag[i*TAG_W +: TAG_W];
          hd[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          hv[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter: a queue-based reference model
// predicts each CDB broadcast and a negedge monitor checks them in order.
module tb_cdb_arbiter;

  localparam int N = 3;

  logic          clk1;
  logic          rst;
  logic          flush;
  logic [N-1:0]  req_valid;
  logic [N*3-1:0]  req_tag;
  logic [N*16-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          cdb_valid;
  logic [2:0]    cdb_tag;
  logic [15:0]   cdb_data;
  logic [1:0]    cdb_src;

  cdb_arbiter #(.N_REQ(N), .TAG_W(3), .DATA_W(16)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  typedef struct {
    int tag;
    int data;
    int src;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Producers: a pending result is presented until the arbiter takes it.
  bit          pend_v    [N];
  logic [2:0]  pend_tag  [N];
  logic [15:0] pend_data [N];

  // Reference model: one held entry per slot plus a rotating start index.
  bit          m_held [N];
  int          m_tag  [N];
  int          m_data [N];
  int          m_rr;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_state();
    checkOutput("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    checkOutput("rst_cdb_tag",   32'(cdb_tag),   32'd0);
    checkOutput("rst_cdb_data",  32'(cdb_data),  32'd0);
    checkOutput("rst_cdb_src",   32'(cdb_src),   32'd0);
  endtask

  task automatic set_pend(input int i, input logic [2:0] t, input logic [15:0] d);
    pend_v[i]    = 1'b1;
    pend_tag[i]  = t;
    pend_data[i] = d;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
  endtask

  // Drives one cycle of inputs, checks req_ready against the model, predicts
  // what the coming edge broadcasts, then advances to just after that edge.
  task automatic applyStimulus(input bit r, input bit f);
    logic [N-1:0] exp_ready;
    int w;
    rst   = r;
    flush = f;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend_v[i];
      req_tag[i*3 +: 3]    = pend_tag[i];
      req_data[i*16 +: 16] = pend_data[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && m_held[(m_rr + k) % N]) w = (m_rr + k) % N;
    for (int i = 0; i < N; i++)
      exp_ready[i] = !f && (!m_held[i] || w == i);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    if (r) begin
      for (int i = 0; i < N; i++) m_held[i] = 1'b0;
      m_rr = 0;
    end else if (f) begin
      for (int i = 0; i < N; i++) m_held[i] = 1'b0;
    end else begin
      if (w >= 0) begin
        sb_q.push_back('{m_tag[w], m_data[w], w, cyc + 1});
        m_held[w] = 1'b0;
        m_rr      = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (pend_v[i] && exp_ready[i]) begin
          m_held[i] = 1'b1;
          m_tag[i]  = int'(pend_tag[i]);
          m_data[i] = int'(pend_data[i]);
          pend_v[i] = 1'b0;
        end
      end
    end
    @(posedge clk1);
    #1;
  endtask

  // Monitor: every broadcast must match the oldest prediction, on its cycle.
  always @(negedge clk1) begin
    exp_t e;
    if (cdb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_bcast: got tag %0h src %0d expected no broadcast at cycle %0d",
                 cdb_tag, cdb_src, cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("bcast_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("bcast_tag",   32'(cdb_tag),  32'(e.tag));
        checkOutput("bcast_data",  32'(cdb_data), 32'(e.data));
        checkOutput("bcast_src",   32'(cdb_src),  32'(e.src));
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("[TB] FAIL missing_bcast: got cdb_valid %b expected tag %0h src %0d at cycle %0d",
               cdb_valid, e.tag, e.src, cyc);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    clear_pend();
    for (int i = 0; i < N; i++) begin
      m_held[i] = 1'b0;
      m_tag[i]  = 0;
      m_data[i] = 0;
    end
    m_rr = 0;

    // Reset, then a single result from the add/sub unit
    repeat (2) @(posedge clk1);
    #1;
    check_reset_state();
    checkOutput("rst_req_ready", 32'(req_ready), 32'b111);
    applyStimulus(0, 0);
    set_pend(0, 3'd5, 16'h00A3);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("idle_cdb_valid", 32'(cdb_valid), 32'd0);
    checkOutput("idle_cdb_tag_hold", 32'(cdb_tag), 32'd5);

    // All three at once from a freshly reset pointer
    applyStimulus(1, 0);
    check_reset_state();
    set_pend(0, 3'd1, 16'h1111);
    set_pend(1, 3'd2, 16'h2222);
    set_pend(2, 3'd3, 16'h3333);
    repeat (5) applyStimulus(0, 0);

    // Rotation: after src 1 wins, slot 2 must precede slot 0
    set_pend(1, 3'd6, 16'hB001);
    applyStimulus(0, 0);
    set_pend(0, 3'd4, 16'hA000);
    set_pend(2, 3'd7, 16'hC002);
    repeat (4) applyStimulus(0, 0);

    // Single requester streaming every cycle
    for (int t = 0; t < 6; t++) begin
      set_pend(1, 3'(t), 16'(16'h5000 + t));
      applyStimulus(0, 0);
    end
    repeat (2) applyStimulus(0, 0);

    // Backpressure on slot 2 until its held value drains
    applyStimulus(1, 0);
    set_pend(0, 3'd2, 16'hD0D0);
    set_pend(2, 3'd2, 16'hE0E0);
    applyStimulus(0, 0);
    set_pend(2, 3'd5, 16'hF00D);
    repeat (5) applyStimulus(0, 0);

    // Flush drops held results; then reset together with flush
    set_pend(0, 3'd3, 16'h0BAD);
    set_pend(1, 3'd4, 16'h0DEF);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    clear_pend();
    repeat (3) applyStimulus(0, 0);
    set_pend(0, 3'd6, 16'h1234);
    set_pend(1, 3'd7, 16'h5678);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    check_reset_state();
    clear_pend();
    applyStimulus(0, 0);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit f;
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 99) < 45)
          set_pend(i, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 4);
      applyStimulus(r, f);
    end
    clear_pend();
    repeat (5) applyStimulus(0, 0);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
